// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares one SDRAM controller Avalon-MM slave port between two masters:
//   M0 - MIPI capture frame writer (write-only, real-time, high priority)
//   M1 - FT232H readout reader     (read-only, bulk)
// Whole bursts are granted. M1 starvation is bounded by STARVE_LIMIT. The
// number of read words issued but not yet returned is capped at MAX_PENDING
// so that M1's return buffer cannot overflow.
//
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   m0_*                       capture write master (address/write/writedata/
//                              burstcount in, waitrequest out)
//   m1_*                       readout read master (address/read/burstcount in,
//                              waitrequest/readdata/readdatavalid out)
//   s_*                        SDRAM controller slave port
//   grant                      one-hot owner: bit0 = M0, bit1 = M1
//
// Optional build macro ARB_STATS_EN adds:
//   stat_clear                 synchronous clear of both counters
//   stat_wr_bursts             completed write bursts (saturating)
//   stat_rd_bursts             accepted read commands (saturating)
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int ADDR_W       = 26,
  parameter int DATA_W       = 16,
  parameter int BURST_W      = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_PENDING  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic               m0_write,
  input  logic [DATA_W-1:0]  m0_writedata,
  input  logic [BURST_W-1:0] m0_burstcount,
  output logic               m0_waitrequest,
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic               m1_read,
  input  logic [BURST_W-1:0] m1_burstcount,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,
  output logic [ADDR_W-1:0]  s_address,
  output logic               s_write,
  output logic               s_read,
  output logic [DATA_W-1:0]  s_writedata,
  output logic [BURST_W-1:0] s_burstcount,
  input  logic               s_waitrequest,
  input  logic [DATA_W-1:0]  s_readdata,
  input  logic               s_readdatavalid,
  output logic [1:0]         grant
`ifdef ARB_STATS_EN
  ,
  input  logic               stat_clear,
  output logic [31:0]        stat_wr_bursts,
  output logic [31:0]        stat_rd_bursts
`endif
);

  localparam int PEND_W   = $clog2(MAX_PENDING + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int SUM_W    = ((PEND_W > BURST_W) ? PEND_W : BURST_W) + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_CMD   = 2'd2
  } state_t;

  state_t              state;
  logic [PEND_W-1:0]   pending;
  logic [STARVE_W-1:0] starve_cnt;
  logic [BURST_W-1:0]  beats_left;

  logic [BURST_W-1:0]  m0_bc_eff;
  logic [BURST_W-1:0]  m1_bc_eff;
  logic [SUM_W-1:0]    pend_after_cmd;
  logic [SUM_W-1:0]    pend_next;
  logic                m0_eligible;
  logic                m1_eligible;
  logic                m1_wins;
  logic                first_beat;
  logic                wr_beat;
  logic                wr_last;
  logic                rd_accept;

  // A burstcount of 0 is handled as a single-beat burst everywhere.
  assign m0_bc_eff = (m0_burstcount == '0) ? BURST_W'(1) : m0_burstcount;
  assign m1_bc_eff = (m1_burstcount == '0) ? BURST_W'(1) : m1_burstcount;

  assign m0_eligible = m0_write;
  assign m1_eligible = m1_read &&
                       ((SUM_W'(pending) + SUM_W'(m1_bc_eff)) <= SUM_W'(MAX_PENDING));
  assign m1_wins     = m1_eligible &&
                       (!m0_eligible || (starve_cnt == STARVE_W'(STARVE_LIMIT)));

  // Slave-side mux follows the registered grant; idle port drives zeros.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    s_address      = '0;
    s_writedata    = '0;
    s_burstcount   = '0;
    s_write        = 1'b0;
    s_read         = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (grant[0]) begin
      s_address      = m0_address;
      s_writedata    = m0_writedata;
      s_burstcount   = m0_bc_eff;
      s_write        = m0_write;
      m0_waitrequest = s_waitrequest;
    end else if (grant[1]) begin
      s_address      = m1_address;
      s_burstcount   = m1_bc_eff;
      s_read         = m1_read;
      m1_waitrequest = s_waitrequest;
    end
  end

  // Read return is passed straight through regardless of ownership.
  assign m1_readdata      = s_readdata;
  assign m1_readdatavalid = s_readdatavalid;

  assign wr_beat   = s_write && !s_waitrequest;
  assign rd_accept = s_read  && !s_waitrequest;

  // beats_left holds the beats still owed after the current one; zero means
  // no beat of this burst has been accepted yet. The burst ends on the beat
  // that would take the remaining count to zero.
  assign first_beat = (beats_left == '0);
  assign wr_last    = wr_beat && (first_beat ? (m0_bc_eff == BURST_W'(1))
                                             : (beats_left == BURST_W'(1)));

  // Net pending update: command words in, one returned word out. A return
  // with nothing outstanding is ignored; the result is clamped for safety.
  always_comb begin
    pend_after_cmd = SUM_W'(pending) + (rd_accept ? SUM_W'(m1_bc_eff) : '0);
    pend_next      = pend_after_cmd;
    if (s_readdatavalid && (pend_after_cmd != '0))
      pend_next = pend_after_cmd - SUM_W'(1);
    if (pend_next > SUM_W'(MAX_PENDING))
      pend_next = SUM_W'(MAX_PENDING);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 2'b00;
      starve_cnt <= '0;
      beats_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m1_wins) begin
            state      <= RD_CMD;
            grant      <= 2'b10;
            starve_cnt <= '0;
          end else if (m0_eligible) begin
            state <= WR_BURST;
            grant <= 2'b01;
            if (m1_eligible && (starve_cnt != STARVE_W'(STARVE_LIMIT)))
              starve_cnt <= starve_cnt + STARVE_W'(1);
          end
        end
        WR_BURST: begin
          if (wr_last) begin
            state      <= IDLE;
            grant      <= 2'b00;
            beats_left <= '0;
          end else if (wr_beat) begin
            beats_left <= first_beat ? (m0_bc_eff - BURST_W'(1))
                                     : (beats_left - BURST_W'(1));
          end
        end
        RD_CMD: begin
          if (rd_accept) begin
            state <= IDLE;
            grant <= 2'b00;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= PEND_W'(pend_next);
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_wr_bursts <= '0;
      stat_rd_bursts <= '0;
    end else if (stat_clear) begin
      stat_wr_bursts <= '0;
      stat_rd_bursts <= '0;
    end else begin
      if (wr_last && (stat_wr_bursts != 32'hFFFF_FFFF))
        stat_wr_bursts <= stat_wr_bursts + 32'd1;
      if (rd_accept && (stat_rd_bursts != 32'hFFFF_FFFF))
        stat_rd_bursts <= stat_rd_bursts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arbiter
//
// Directed self-checking bench for sdram_port_arbiter with default parameters
// (STARVE_LIMIT = 4, MAX_PENDING = 8). The slave side is driven directly from
// the stimulus sequence. Inputs change 1 ns after a rising edge and outputs
// are sampled between edges. Statistics checks compile in with ARB_STATS_EN.
// -----------------------------------------------------------------------------
module tb_sdram_port_arbiter;

  localparam int ADDR_W  = 26;
  localparam int DATA_W  = 16;
  localparam int BURST_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  m0_address;
  logic               m0_write;
  logic [DATA_W-1:0]  m0_writedata;
  logic [BURST_W-1:0] m0_burstcount;
  logic               m0_waitrequest;
  logic [ADDR_W-1:0]  m1_address;
  logic               m1_read;
  logic [BURST_W-1:0] m1_burstcount;
  logic               m1_waitrequest;
  logic [DATA_W-1:0]  m1_readdata;
  logic               m1_readdatavalid;
  logic [ADDR_W-1:0]  s_address;
  logic               s_write;
  logic               s_read;
  logic [DATA_W-1:0]  s_writedata;
  logic [BURST_W-1:0] s_burstcount;
  logic               s_waitrequest;
  logic [DATA_W-1:0]  s_readdata;
  logic               s_readdatavalid;
  logic [1:0]         grant;
`ifdef ARB_STATS_EN
  logic               stat_clear;
  logic [31:0]        stat_wr_bursts;
  logic [31:0]        stat_rd_bursts;
`endif

  int total = 0;
  int bad   = 0;

  sdram_port_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_burstcount    (m0_burstcount),
    .m0_waitrequest   (m0_waitrequest),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_burstcount    (m1_burstcount),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_write          (s_write),
    .s_read           (s_read),
    .s_writedata      (s_writedata),
    .s_burstcount     (s_burstcount),
    .s_waitrequest    (s_waitrequest),
    .s_readdata       (s_readdata),
    .s_readdatavalid  (s_readdatavalid),
    .grant            (grant)
`ifdef ARB_STATS_EN
    ,
    .stat_clear       (stat_clear),
    .stat_wr_bursts   (stat_wr_bursts),
    .stat_rd_bursts   (stat_rd_bursts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step edges until some master is granted, at most 8 edges.
  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while ((grant == 2'b00) && (cyc < 8));
  endtask

  initial begin
    int cyc;
    int k;
    int stall;
    logic w;
    logic [1:0] exp_order [10];

    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                  2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    reset           = 1'b1;
    m0_address      = '0;
    m0_write        = 1'b0;
    m0_writedata    = '0;
    m0_burstcount   = '0;
    m1_address      = '0;
    m1_read         = 1'b0;
    m1_burstcount   = '0;
    s_waitrequest   = 1'b0;
    s_readdata      = '0;
    s_readdatavalid = 1'b0;
`ifdef ARB_STATS_EN
    stat_clear      = 1'b0;
`endif

    // ---- reset state ----
    #12;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_s_write", 32'(s_write), 32'h0);
    check("rst_s_read", 32'(s_read), 32'h0);
    check("rst_m0_wait", 32'(m0_waitrequest), 32'h1);
    check("rst_m1_wait", 32'(m1_waitrequest), 32'h1);
    #10 reset = 1'b0;
    tick();

    // ---- M0 burst of 4, no stalls ----
    m0_write      = 1'b1;
    m0_address    = 26'h100;
    m0_writedata  = 16'hA000;
    m0_burstcount = 4'd4;
    wait_grant(cyc);
    check("b4_grant_latency", 32'(cyc), 32'd1);
    check("b4_grant", 32'(grant), 32'h1);
    for (int i = 0; i < 4; i++) begin
      m0_writedata = 16'hA000 + 16'(i);
      #1;
      check("b4_s_write", 32'(s_write), 32'h1);
      check("b4_s_data", 32'(s_writedata), 32'hA000 + 32'(i));
      check("b4_s_addr", 32'(s_address), 32'h100);
      check("b4_s_bc", 32'(s_burstcount), 32'd4);
      check("b4_m0_wait", 32'(m0_waitrequest), 32'h0);
      tick();
    end
    m0_write = 1'b0;
    #1;
    check("b4_done_grant", 32'(grant), 32'h0);
    check("b4_done_s_write", 32'(s_write), 32'h0);
    check("b4_done_m0_wait", 32'(m0_waitrequest), 32'h1);
    tick();
    check("b4_stay_idle", 32'(grant), 32'h0);

    // ---- M0 burst of 8 with a 3-cycle stall after beat 2 ----
    m0_write      = 1'b1;
    m0_address    = 26'h400;
    m0_burstcount = 4'd8;
    m0_writedata  = 16'hB000;
    wait_grant(cyc);
    check("b8_grant", 32'(grant), 32'h1);
    k = 0;
    stall = 0;
    cyc = 0;
    while ((k < 8) && (cyc < 30)) begin
      w = (k == 2) && (stall < 3);
      s_waitrequest = w;
      m0_writedata  = 16'hB000 + 16'(k);
      #1;
      check("b8_grant_held", 32'(grant), 32'h1);
      check("b8_m0_wait", 32'(m0_waitrequest), 32'(w));
      check("b8_s_data", 32'(s_writedata), 32'hB000 + 32'(k));
      tick();
      cyc++;
      if (w) stall++;
      else   k++;
    end
    s_waitrequest = 1'b0;
    m0_write      = 1'b0;
    #1;
    check("b8_beats", 32'(k), 32'd8);
    check("b8_stalls", 32'(stall), 32'd3);
    check("b8_cycles", 32'(cyc), 32'd11);
    check("b8_done_grant", 32'(grant), 32'h0);

    // ---- both masters, bursts of 1: starvation bound ----
    m0_write      = 1'b1;
    m0_burstcount = 4'd1;
    m0_address    = 26'h800;
    m1_read       = 1'b1;
    m1_burstcount = 4'd1;
    m1_address    = 26'h3000;
    for (int g = 0; g < 10; g++) begin
      cyc = 0;
      do begin
        tick();
        s_readdatavalid = 1'b0;
        cyc++;
      end while ((grant == 2'b00) && (cyc < 8));
      check("starve_order", 32'(grant), 32'(exp_order[g]));
      if (grant == 2'b10) begin
        // Return the single read word in the cycle the command is accepted.
        s_readdata      = 16'h5A00 + 16'(g);
        s_readdatavalid = 1'b1;
        #1;
        check("starve_rdvalid", 32'(m1_readdatavalid), 32'h1);
        check("starve_rddata", 32'(m1_readdata), 32'h5A00 + 32'(g));
      end
    end
    tick();
    s_readdatavalid = 1'b0;
    m0_write        = 1'b0;
    m1_read         = 1'b0;
    tick();
    check("starve_idle", 32'(grant), 32'h0);

    // ---- pending limit ----
    m1_read       = 1'b1;
    m1_burstcount = 4'd8;
    m1_address    = 26'h2000;
    wait_grant(cyc);
    check("pend_b8_grant", 32'(grant), 32'h2);
    check("pend_b8_s_read", 32'(s_read), 32'h1);
    check("pend_b8_s_bc", 32'(s_burstcount), 32'd8);
    check("pend_b8_m1_wait", 32'(m1_waitrequest), 32'h0);
    tick();  // command accepted, pending = 8
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pend8_blocked", 32'(grant), 32'h0);
      check("pend8_m1_wait", 32'(m1_waitrequest), 32'h1);
    end
    s_readdata      = 16'h1234;
    s_readdatavalid = 1'b1;
    #1;
    check("pend_rdvalid", 32'(m1_readdatavalid), 32'h1);
    check("pend_rddata", 32'(m1_readdata), 32'h1234);
    tick();  // pending = 7
    s_readdatavalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pend7_b8_blocked", 32'(grant), 32'h0);
    end
    m1_burstcount = 4'd1;
    wait_grant(cyc);
    check("pend7_b1_latency", 32'(cyc), 32'd1);
    check("pend7_b1_grant", 32'(grant), 32'h2);
    s_readdatavalid = 1'b1;  // same-cycle accept and return: net 0
    tick();
    s_readdatavalid = 1'b0;
    wait_grant(cyc);
    check("pend7_again_grant", 32'(grant), 32'h2);
    tick();  // accepted, pending = 8
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pend8_b1_blocked", 32'(grant), 32'h0);
    end
    m1_read = 1'b0;
    // Nine returns: eight drain pending, the ninth must be ignored.
    s_readdatavalid = 1'b1;
    repeat (9) tick();
    s_readdatavalid = 1'b0;
    m1_read       = 1'b1;
    m1_burstcount = 4'd8;
    wait_grant(cyc);
    check("pend0_b8_grant", 32'(grant), 32'h2);
    tick();  // pending = 8
    m1_burstcount = 4'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pend_no_underflow", 32'(grant), 32'h0);
    end
    m1_read = 1'b0;
    s_readdatavalid = 1'b1;
    repeat (8) tick();
    s_readdatavalid = 1'b0;

`ifdef ARB_STATS_EN
    // ---- statistics counters ----
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    check("stat_clr_wr", stat_wr_bursts, 32'd0);
    check("stat_clr_rd", stat_rd_bursts, 32'd0);
    m0_burstcount = 4'd1;
    m1_burstcount = 4'd1;
    for (int i = 0; i < 3; i++) begin
      m0_write = 1'b1;
      wait_grant(cyc);
      tick();
      m0_write = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      m1_read = 1'b1;
      wait_grant(cyc);
      s_readdatavalid = 1'b1;
      tick();
      s_readdatavalid = 1'b0;
      m1_read = 1'b0;
    end
    check("stat_wr3", stat_wr_bursts, 32'd3);
    check("stat_rd2", stat_rd_bursts, 32'd2);
    m0_write = 1'b1;
    wait_grant(cyc);
    stat_clear = 1'b1;  // clear wins over the completing burst
    tick();
    stat_clear = 1'b0;
    m0_write   = 1'b0;
    check("stat_clr_prio_wr", stat_wr_bursts, 32'd0);
    check("stat_clr_prio_rd", stat_rd_bursts, 32'd0);
    tick();
`endif

    // ---- reset during beat 3 of an 8-beat burst ----
    m0_write      = 1'b1;
    m0_burstcount = 4'd8;
    m0_address    = 26'h600;
    m0_writedata  = 16'hC000;
    wait_grant(cyc);
    check("rstmid_grant", 32'(grant), 32'h1);
    tick();
    tick();  // beats 1 and 2 accepted
    check("rstmid_beat3_write", 32'(s_write), 32'h1);
    reset = 1'b1;
    #1;
    check("rstmid_s_write", 32'(s_write), 32'h0);
    check("rstmid_grant0", 32'(grant), 32'h0);
    check("rstmid_m0_wait", 32'(m0_waitrequest), 32'h1);
    check("rstmid_m1_wait", 32'(m1_waitrequest), 32'h1);
    #4 reset = 1'b0;
    wait_grant(cyc);
    check("rstmid_regrant_latency", 32'(cyc), 32'd1);
    check("rstmid_regrant", 32'(grant), 32'h1);
    repeat (8) tick();
    m0_write = 1'b0;
    #1;
    check("rstmid_full_burst_done", 32'(grant), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
